inst_fetch: RTL

Instruction-fetch stage directly downstream of the PC/branch-predictor register. Each cycle it looks up the current `pc` in a direct-mapped, word-per-line instruction cache. On a hit it hands the instruction to the IF/ID latch. On a miss it stalls the PC register, reads the word byte-serially over the shared memory-controller port, fills the line, and replays the lookup. Index and tag slicing match the predictor (index `pc[8:2]`, tag `pc[17:9]`).

---
 rtl/inst_fetch.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: direct-mapped, one-word-per-line I-cache with a
// byte-serial refill over the shared memory-controller port.
module inst_fetch #(
    parameter int LINES = 128,
    parameter int TAG_W = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        jump_flag,
    input  logic        stall_in,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        stall_req,
    input  logic        mem_grant,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_din
);

    localparam int IDX_W = $clog2(LINES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t             r_state;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES];
    logic [31:0]        r_fill_pc;
    logic [2:0]         r_issue_cnt;
    logic               r_inflight;
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_word;
    logic [31:0]        r_if_pc;
    logic [31:0]        r_if_inst;
    logic               r_if_valid;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic [31:0]        w_line_pc;
    logic               w_hit;
    logic               w_lookup;
    logic               w_miss;
    logic               w_fill_done;
    logic               w_rd_en;
    logic               w_stall;
    logic [31:0]        w_addr;

    assign w_idx      = pc[IDX_W+1:2];
    assign w_tag      = pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_fill_idx = r_fill_pc[IDX_W+1:2];
    assign w_fill_tag = r_fill_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_line_pc  = {pc[31:2], 2'b00};

    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_lookup    = (r_state == S_IDLE) && !stall_in && !jump_flag && !rst;
    assign w_miss      = w_lookup && !w_hit;
    assign w_fill_done = (r_state == S_FILL) && !jump_flag && !rst
                         && r_inflight && (r_byte_idx == 2'd3);

    // Byte 0 of a miss goes out in the lookup cycle itself to save a cycle.
    always_comb begin
        w_rd_en = 1'b0;
        w_stall = 1'b0;
        w_addr  = '0;
        if (!rst && !jump_flag) begin
            case (r_state)
                S_IDLE: begin
                    w_stall = w_miss;
                    w_rd_en = w_miss && mem_grant;
                    w_addr  = w_line_pc;
                end
                S_FILL: begin
                    w_stall = 1'b1;
                    w_rd_en = !r_issue_cnt[2] && mem_grant;
                    w_addr  = r_fill_pc + {30'b0, r_issue_cnt[1:0]};
                end
                default: ;
            endcase
        end
    end

    assign stall_req = w_stall;
    assign mem_rd_en = w_rd_en;
    assign mem_addr  = w_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_fill_pc   <= '0;
            r_issue_cnt <= '0;
            r_inflight  <= 1'b0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_if_pc     <= '0;
            r_if_inst   <= '0;
            r_if_valid  <= 1'b0;
        end else if (jump_flag) begin
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
            r_if_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!stall_in) begin
                        if (w_hit) begin
                            r_if_pc    <= pc;
                            r_if_inst  <= r_data[w_idx];
                            r_if_valid <= 1'b1;
                        end else begin
                            r_if_valid  <= 1'b0;
                            r_fill_pc   <= w_line_pc;
                            r_issue_cnt <= mem_grant ? 3'd1 : 3'd0;
                            r_inflight  <= mem_grant;
                            r_byte_idx  <= 2'd0;
                            r_state     <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (w_rd_en) begin
                        r_issue_cnt <= r_issue_cnt + 3'd1;
                        r_inflight  <= 1'b1;
                        r_byte_idx  <= r_issue_cnt[1:0];
                    end else begin
                        r_inflight <= 1'b0;
                    end
                    if (r_inflight) begin
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= mem_din;
                            2'd1: r_word[15:8]  <= mem_din;
                            2'd2: r_word[23:16] <= mem_din;
                            default: begin
                                r_valid[w_fill_idx] <= 1'b1;
                                r_state             <= S_IDLE;
                            end
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid vector alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_data[w_fill_idx] <= {mem_din, r_word};
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;
    assign if_valid = r_if_valid;

endmodule
